// File: rtl/text_render_ctrl.sv
// Text renderer: fetches characters from text RAM, runs them through char_decoder
// and streams each 8x16 glyph to the framebuffer as coloured pixels, one per handshake.
module text_render_ctrl #(
   parameter int TEXT_ADDR_W = 8,
   parameter int X_W         = 9,
   parameter int Y_W         = 8,
   parameter int COLOR_W     = 3,
   parameter int COLS        = 40
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [TEXT_ADDR_W-1:0] base_addr,
   input  logic [TEXT_ADDR_W-1:0] length,
   input  logic [X_W-1:0]         origin_x,
   input  logic [Y_W-1:0]         origin_y,
   input  logic [COLOR_W-1:0]     fg_color,
   input  logic [COLOR_W-1:0]     bg_color,
   output logic                   busy,
   output logic                   done,
   output logic [TEXT_ADDR_W-1:0] text_addr,
   input  logic [6:0]             text_data,
   output logic [6:0]             dec_char,
   input  logic [127:0]           dec_pixels,
   output logic                   pix_valid,
   input  logic                   pix_ready,
   output logic [X_W-1:0]         pix_x,
   output logic [Y_W-1:0]         pix_y,
   output logic [COLOR_W-1:0]     pix_color
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, CAPTURE, DRAW, ADVANCE, DONE
   } state_t;

   state_t                 state, state_nxt;

   logic [TEXT_ADDR_W-1:0] base_q, len_q, idx, idx_inc;
   logic [X_W-1:0]         ox_q, char_x, nxt_x;
   logic [Y_W-1:0]         oy_q, line, char_y, nxt_y;
   logic [COLOR_W-1:0]     fg_q, bg_q;
   logic [COL_W-1:0]       col;
   logic [126:0]           glyph;
   logic [6:0]             p, p_nxt;
   logic                   xfer, last_px, is_nl;

   assign idx_inc = idx + TEXT_ADDR_W'(1);
   assign char_x  = ox_q + (X_W'(col) << 3);
   assign char_y  = oy_q + (line << 4);
   assign p_nxt   = p + 7'd1;
   assign nxt_x   = char_x + X_W'(p_nxt[2:0]);
   assign nxt_y   = char_y + Y_W'(p_nxt[6:3]);
   assign xfer    = (state == DRAW) && pix_ready;
   assign last_px = (p == 7'd127);
   assign is_nl   = (text_data == 7'h0A);

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign pix_valid = (state == DRAW);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (length == '0) ? DONE : FETCH;
         FETCH:   state_nxt = LOAD;
         LOAD:    state_nxt = is_nl ? ADVANCE : CAPTURE;
         CAPTURE: state_nxt = DRAW;
         DRAW:    if (xfer && last_px) state_nxt = ADVANCE;
         ADVANCE: state_nxt = (idx_inc == len_q) ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and output registers; text_addr is loaded on every entry to FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         text_addr <= '0;
         dec_char  <= 7'h20;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_color <= '0;
         idx       <= '0;
         col       <= '0;
         line      <= '0;
         p         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx  <= '0;
                  col  <= '0;
                  line <= '0;
                  if (length != '0) text_addr <= base_addr;
               end
            end
            LOAD: begin
               dec_char <= text_data;
               if (is_nl) begin
                  col  <= '0;
                  line <= line + Y_W'(1);
               end
            end
            CAPTURE: begin
               p         <= '0;
               pix_x     <= char_x;
               pix_y     <= char_y;
               pix_color <= dec_pixels[127] ? fg_q : bg_q;
            end
            DRAW: begin
               if (xfer) begin
                  if (last_px) begin
                     if (col == COL_W'(COLS - 1)) begin
                        col  <= '0;
                        line <= line + Y_W'(1);
                     end else begin
                        col <= col + COL_W'(1);
                     end
                  end else begin
                     p         <= p_nxt;
                     pix_x     <= nxt_x;
                     pix_y     <= nxt_y;
                     pix_color <= glyph[126] ? fg_q : bg_q;
                  end
               end
            end
            ADVANCE: begin
               idx <= idx_inc;
               if (idx_inc != len_q) text_addr <= base_q + idx_inc;
            end
            default: ;
         endcase
      end
   end

   // Job parameters and the glyph shift register; the MSB is consumed at capture
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         base_q <= base_addr;
         len_q  <= length;
         ox_q   <= origin_x;
         oy_q   <= origin_y;
         fg_q   <= fg_color;
         bg_q   <= bg_color;
      end
      if (state == CAPTURE) glyph <= dec_pixels[126:0];
      else if (xfer)        glyph <= glyph << 1;
   end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl: text RAM and a stand-in glyph decoder around
// the controller, with transfers recorded and compared against a layout model.
module tb_text_render_ctrl;

   localparam int TAW = 8, XW = 9, YW = 8, CW = 3, NCOLS = 2;

   logic           clk, reset, start;
   logic [TAW-1:0] base_addr, length, text_addr;
   logic [XW-1:0]  origin_x, pix_x;
   logic [YW-1:0]  origin_y, pix_y;
   logic [CW-1:0]  fg_color, bg_color, pix_color;
   logic           busy, done, pix_valid, pix_ready;
   logic [6:0]     text_data, dec_char;
   logic [127:0]   dec_pixels;

   text_render_ctrl #(
      .TEXT_ADDR_W(TAW), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .COLS(NCOLS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .origin_x(origin_x), .origin_y(origin_y), .fg_color(fg_color), .bg_color(bg_color),
      .busy(busy), .done(done), .text_addr(text_addr), .text_data(text_data),
      .dec_char(dec_char), .dec_pixels(dec_pixels), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] ram [256];
   always @(posedge clk) text_data <= ram[text_addr];

   // Stand-in decoder: row 0 blank, rows 1..15 = (char | 0x20), leftmost column at the MSB
   function automatic logic [127:0] glyph(input logic [6:0] ch);
      logic [127:0] g;
      logic [7:0]   b;
      g = '0;
      b = {1'b0, ch} | 8'h20;
      for (int r = 1; r < 16; r++) g[127-8*r -: 8] = b;
      return g;
   endfunction

   assign dec_pixels = glyph(dec_char);

   int n_tests = 0, n_fail = 0;
   int got_x[$], got_y[$], got_c[$], exp_x[$], exp_y[$], exp_c[$], ref_c[$];
   int first_vld, done_n, done_cnt, busy_n, busy_after, stab_err;
   int addr1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic build_exp(input int base, input int len, input int ox, input int oy,
                            input int fg, input int bg);
      int col, line;
      logic [127:0] g;
      exp_x.delete(); exp_y.delete(); exp_c.delete();
      col = 0; line = 0;
      for (int i = 0; i < len; i++) begin
         if (ram[(base + i) % 256] == 7'h0A) begin
            col = 0; line++;
         end else begin
            g = glyph(ram[(base + i) % 256]);
            for (int p = 0; p < 128; p++) begin
               exp_x.push_back((ox + col * 8 + p % 8) % 512);
               exp_y.push_back((oy + line * 16 + p / 8) % 256);
               exp_c.push_back(g[127 - p] ? fg : bg);
            end
            col++;
            if (col == NCOLS) begin col = 0; line++; end
         end
      end
   endtask

   task automatic cmp_pixels(input string tag);
      int errs;
      errs = 0;
      chk({tag, "_count"}, got_x.size(), exp_x.size());
      for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
         if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_c[i] != exp_c[i]) errs++;
      chk({tag, "_pixel_errs"}, errs, 0);
   endtask

   // Starts a job and observes it cycle by cycle; cycle n is the n-th cycle after the start edge
   task automatic run_job(input int base, input int len, input int ox, input int oy,
                          input int fg, input int bg, input bit bp, input int abort_after);
      int n, hx, hy, hc;
      bit held;
      got_x.delete(); got_y.delete(); got_c.delete();
      first_vld = -1; done_n = -1; done_cnt = 0; busy_n = 0; busy_after = -1;
      stab_err = 0; held = 0; hx = 0; hy = 0; hc = 0;
      @(posedge clk); #1;
      base_addr = TAW'(base); length = TAW'(len);
      origin_x = XW'(ox); origin_y = YW'(oy);
      fg_color = CW'(fg); bg_color = CW'(bg);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (n <= 3000) begin
         pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (n == 1) addr1 = int'(text_addr);
         if (held && pix_valid &&
             (int'(pix_x) != hx || int'(pix_y) != hy || int'(pix_color) != hc)) stab_err++;
         held = pix_valid && !pix_ready;
         hx = int'(pix_x); hy = int'(pix_y); hc = int'(pix_color);
         if (pix_valid && first_vld < 0) first_vld = n;
         if (pix_valid && pix_ready) begin
            got_x.push_back(int'(pix_x));
            got_y.push_back(int'(pix_y));
            got_c.push_back(int'(pix_color));
         end
         if (done_n > 0 && n == done_n + 1) begin
            busy_after = int'(busy);
            break;
         end
         if (busy) busy_n++;
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         if (abort_after > 0 && got_x.size() == abort_after) begin
            @(posedge clk); #1;
            reset = 1'b1;
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      if (n > 3000) chk("job_timeout", n, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
      base_addr = '0; length = '0; origin_x = '0; origin_y = '0;
      fg_color = '0; bg_color = '0;
      for (int i = 0; i < 256; i++) ram[i] = 7'h3F;
      ram[8'h10] = 7'h41;
      ram[8'h20] = 7'h41; ram[8'h21] = 7'h42; ram[8'h22] = 7'h43;
      ram[8'h30] = 7'h41; ram[8'h31] = 7'h0A; ram[8'h32] = 7'h42;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_text_addr", int'(text_addr), 0);
      chk("rst_dec_char", int'(dec_char), 32);
      chk("rst_pix_x", int'(pix_x), 0);
      chk("rst_pix_y", int'(pix_y), 0);
      chk("rst_pix_color", int'(pix_color), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single 'A' at the origin, sink always ready
      run_job(8'h10, 1, 0, 0, 7, 0, 1'b0, 0);
      build_exp(8'h10, 1, 0, 0, 7, 0);
      chk("single_text_addr", addr1, 16);
      chk("single_first_valid", first_vld, 4);
      chk("single_done_cycle", done_n, 133);
      chk("single_done_pulses", done_cnt, 1);
      chk("single_busy_cycles", busy_n, 133);
      chk("single_busy_after", busy_after, 0);
      cmp_pixels("single");
      chk("single_px22_x", qget(got_x, 18), 2);
      chk("single_px22_y", qget(got_y, 18), 2);
      chk("single_px22_color", qget(got_c, 18), 7);
      chk("single_px00_color", qget(got_c, 0), 0);
      ref_c = got_c;

      // Same job under random backpressure
      run_job(8'h10, 1, 0, 0, 7, 0, 1'b1, 0);
      cmp_pixels("bp");
      chk("bp_stable_errs", stab_err, 0);
      chk("bp_done_pulses", done_cnt, 1);
      begin
         int errs;
         errs = 0;
         for (int i = 0; i < 128; i++) if (qget(got_c, i) != qget(ref_c, i)) errs++;
         chk("bp_color_vs_unstalled", errs, 0);
      end

      // Wrap after two columns
      run_job(8'h20, 3, 8, 4, 2, 5, 1'b0, 0);
      build_exp(8'h20, 3, 8, 4, 2, 5);
      cmp_pixels("wrap");
      chk("wrap_B_x", qget(got_x, 128), 16);
      chk("wrap_B_y", qget(got_y, 128), 4);
      chk("wrap_C_x", qget(got_x, 256), 8);
      chk("wrap_C_y", qget(got_y, 256), 20);
      chk("wrap_done_cycle", done_n, 397);

      // Newline between two glyphs
      run_job(8'h30, 3, 100, 30, 1, 6, 1'b0, 0);
      build_exp(8'h30, 3, 100, 30, 1, 6);
      cmp_pixels("newline");
      chk("newline_B_x", qget(got_x, 128), 100);
      chk("newline_B_y", qget(got_y, 128), 46);
      chk("newline_done_cycle", done_n, 268);

      // Zero-length job leaves the RAM address untouched
      begin
         int addr_before;
         addr_before = int'(text_addr);
         run_job(8'h50, 0, 0, 0, 7, 0, 1'b0, 0);
         chk("zero_text_addr", addr1, addr_before);
         chk("zero_done_cycle", done_n, 1);
         chk("zero_busy_cycles", busy_n, 1);
         chk("zero_first_valid", first_vld, -1);
         chk("zero_pixels", got_x.size(), 0);
      end

      // Coordinates truncate at the right and bottom edges
      run_job(8'h10, 1, 508, 250, 4, 3, 1'b0, 0);
      build_exp(8'h10, 1, 508, 250, 4, 3);
      cmp_pixels("trunc");
      chk("trunc_x_wrap", qget(got_x, 4), 0);
      chk("trunc_y_wrap", qget(got_y, 48), 0);

      // Reset during DRAW after 50 transfers, then a clean rerun
      run_job(8'h10, 1, 0, 0, 7, 0, 1'b0, 50);
      chk("abort_transfers", got_x.size(), 50);
      chk("abort_no_done_before", done_cnt, 0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_pix_valid", int'(pix_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_idle_done", int'(done), 0);
      run_job(8'h10, 1, 0, 0, 7, 0, 1'b0, 0);
      build_exp(8'h10, 1, 0, 0, 7, 0);
      cmp_pixels("rerun");
      chk("rerun_first_valid", first_vld, 4);
      chk("rerun_done_cycle", done_n, 133);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
